// File: rtl/stb_window_ctrl_if.sv
// Result channel between the window sequencer and the binary consumer.
// The producer drives result/result_valid; the consumer drives result_ready.
interface stb_window_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready;

    modport master (output result, output result_valid, input result_ready);
    modport slave  (input result, input result_valid, output result_ready);
endinterface

// File: rtl/stb_window_ctrl.sv
// Start-triggered 2^L-cycle window that counts stochastic ones and hands out a scaled result.
// Optional abort input is enabled by defining STB_WINDOW_CTRL_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for start; result held, result_valid low
// RUN   | stream enabled, accumulating bit_in for 2^L cycles
// HOLD  | result_valid high until the consumer accepts it
module stb_window_ctrl #(
    parameter int WIDTH = 8,
    parameter int LW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [LW-1:0] len_log2,
    input  logic          bit_in,
`ifdef STB_WINDOW_CTRL_ABORT_EN
    input  logic          abort,
`endif
    output logic          stream_en,
    output logic          busy,
    stb_window_ctrl_if.master res_if
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t         state;
    logic [LW-1:0]  l_reg;
    logic [WIDTH:0] ones;
    logic [WIDTH:0] cyc;
    logic [WIDTH:0] last_cyc;
    logic [WIDTH:0] final_cnt;
    logic [WIDTH:0] scaled;
    logic [LW-1:0]  sh_amt;
    logic [WIDTH-1:0] sat_result;
    logic           abort_hit;

`ifdef STB_WINDOW_CTRL_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        if (l == '0 || l > LW'(WIDTH)) begin
            return LW'(WIDTH);
        end
        return l;
    endfunction

    // final count never exceeds 2^L, so the shifted value fits in WIDTH+1 bits
    assign last_cyc   = ((WIDTH + 1)'(1) << l_reg) - (WIDTH + 1)'(1);
    assign final_cnt  = ones + {{WIDTH{1'b0}}, bit_in};
    assign sh_amt     = LW'(WIDTH) - l_reg;
    assign scaled     = final_cnt << sh_amt;
    assign sat_result = scaled[WIDTH] ? {WIDTH{1'b1}} : scaled[WIDTH-1:0];

    assign stream_en = (state == RUN);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state               <= IDLE;
            l_reg               <= LW'(WIDTH);
            ones                <= '0;
            cyc                 <= '0;
            res_if.result       <= '0;
            res_if.result_valid <= 1'b0;
        end else if (abort_hit) begin
            state               <= IDLE;
            res_if.result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        l_reg <= clamp_len(len_log2);
                        ones  <= '0;
                        cyc   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cyc == last_cyc) begin
                        res_if.result       <= sat_result;
                        res_if.result_valid <= 1'b1;
                        state               <= HOLD;
                    end else begin
                        ones <= final_cnt;
                        cyc  <= cyc + (WIDTH + 1)'(1);
                    end
                end
                HOLD: begin
                    if (res_if.result_ready) begin
                        res_if.result_valid <= 1'b0;
                        if (start) begin
                            l_reg <= clamp_len(len_log2);
                            ones  <= '0;
                            cyc   <= '0;
                            state <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state               <= IDLE;
                    res_if.result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stb_window_ctrl.sv
// Directed bench for stb_window_ctrl (WIDTH=8) with hand-computed expectations.
// Abort scenarios are exercised when STB_WINDOW_CTRL_ABORT_EN is defined.
module tb_stb_window_ctrl;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [3:0] len_log2;
    logic       bit_in;
    logic       stream_en;
    logic       busy;
`ifdef STB_WINDOW_CTRL_ABORT_EN
    logic       abort;
`endif

    int checks = 0;
    int errors = 0;

    stb_window_ctrl_if #(.WIDTH(8)) rif ();

    stb_window_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .len_log2  (len_log2),
        .bit_in    (bit_in),
`ifdef STB_WINDOW_CTRL_ABORT_EN
        .abort     (abort),
`endif
        .stream_en (stream_en),
        .busy      (busy),
        .res_if    (rif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just after the edge that put the DUT in RUN; feeds n bits and
    // leaves the DUT just after the edge that entered HOLD.
    task automatic feed(input string tag, input int n, input logic [255:0] pat,
                        input logic [7:0] exp_res);
        int en_cnt;
        int valid_seen;
        en_cnt     = 0;
        valid_seen = 0;
        start      = 1'b0;
        for (int i = 0; i < n; i++) begin
            bit_in = pat[i];
            if (stream_en === 1'b1) en_cnt++;
            if (rif.result_valid !== 1'b0) valid_seen++;
            tick();
        end
        bit_in = 1'b0;
        check({tag, "_en_cycles"}, en_cnt, n);
        check({tag, "_valid_in_run"}, valid_seen, 0);
        check({tag, "_valid"}, rif.result_valid, 1);
        check({tag, "_result"}, rif.result, exp_res);
        check({tag, "_en_off"}, stream_en, 0);
    endtask

    task automatic accept_to_idle(input string tag, input logic [7:0] exp_res);
        rif.result_ready = 1'b1;
        tick();
        rif.result_ready = 1'b0;
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_valid"}, rif.result_valid, 0);
        check({tag, "_idle_result"}, rif.result, exp_res);
    endtask

    initial begin
        int busy_cnt;
        resetn           = 1'b0;
        start            = 1'b0;
        len_log2         = 4'd0;
        bit_in           = 1'b0;
        rif.result_ready = 1'b0;
`ifdef STB_WINDOW_CTRL_ABORT_EN
        abort            = 1'b0;
`endif
        tick();
        tick();
        check("rst_result", rif.result, 0);
        check("rst_valid", rif.result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_en", stream_en, 0);
        resetn = 1'b1;
        tick();
        check("idle_stay", busy, 0);

        // L=3 all ones: 8<<5 = 256 saturates to 255
        start = 1'b1; len_log2 = 4'd3;
        tick();
        check("t1_busy", busy, 1);
        feed("t1", 8, {256{1'b1}}, 8'd255);
        accept_to_idle("t1", 8'd255);

        // L=3 alternating 1,0: 4 ones -> 4<<5 = 128
        start = 1'b1; len_log2 = 4'd3;
        tick();
        feed("t2", 8, {32{8'b0101_0101}}, 8'd128);
        accept_to_idle("t2", 8'd128);

        // len_log2=0 clamps to 8, all zeros -> 0, busy for 257 cycles
        start = 1'b1; len_log2 = 4'd0;
        tick();
        busy_cnt = 0;
        start = 1'b0;
        rif.result_ready = 1'b1;
        for (int i = 0; i < 300 && busy === 1'b1; i++) begin
            busy_cnt++;
            if (busy_cnt == 257) check("t3_valid", rif.result_valid, 1);
            tick();
        end
        rif.result_ready = 1'b0;
        check("t3_busy_cycles", busy_cnt, 257);
        check("t3_result", rif.result, 0);

        // len_log2=12 clamps to 8: 128 ones then zeros -> 128
        start = 1'b1; len_log2 = 4'd12;
        tick();
        feed("t4", 256, {{128{1'b0}}, {128{1'b1}}}, 8'd128);
        accept_to_idle("t4", 8'd128);

        // L=2 bits 1,1,0,1 -> 3<<6 = 192, then backpressure with start toggling
        start = 1'b1; len_log2 = 4'd2;
        tick();
        feed("t5", 4, 256'b1011, 8'd192);
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            tick();
            check("t5_bp_busy", busy, 1);
            check("t5_bp_en", stream_en, 0);
            check("t5_bp_valid", rif.result_valid, 1);
            check("t5_bp_result", rif.result, 192);
        end
        // back-to-back into L=1: bits 1,0 -> 1<<7 = 128
        start = 1'b1; len_log2 = 4'd1; rif.result_ready = 1'b1;
        tick();
        rif.result_ready = 1'b0;
        check("t6_b2b_en", stream_en, 1);
        check("t6_b2b_valid", rif.result_valid, 0);
        feed("t6", 2, 256'b01, 8'd128);
        accept_to_idle("t6", 8'd128);

        // reset halfway through an L=4 window of ones
        start = 1'b1; len_log2 = 4'd4;
        tick();
        start = 1'b0; bit_in = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        resetn = 1'b0;
        #2;
        check("t7_rst_busy", busy, 0);
        check("t7_rst_en", stream_en, 0);
        check("t7_rst_valid", rif.result_valid, 0);
        check("t7_rst_result", rif.result, 0);
        resetn = 1'b1; bit_in = 1'b0;
        tick();
        // first three ones only -> 3<<4 = 48
        start = 1'b1; len_log2 = 4'd4;
        tick();
        feed("t7", 16, 256'b111, 8'd48);
        accept_to_idle("t7", 8'd48);

`ifdef STB_WINDOW_CTRL_ABORT_EN
        start = 1'b1; len_log2 = 4'd3;
        tick();
        start = 1'b0; bit_in = 1'b1;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_run_busy", busy, 0);
        check("ab_run_valid", rif.result_valid, 0);
        check("ab_run_result", rif.result, 48);
        tick();
        check("ab_run_stays_idle", busy, 0);
        start = 1'b1; len_log2 = 4'd1;
        tick();
        feed("ab", 2, 256'b11, 8'd255);
        abort = 1'b1; start = 1'b1; rif.result_ready = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0; rif.result_ready = 1'b0;
        check("ab_hold_busy", busy, 0);
        check("ab_hold_valid", rif.result_valid, 0);
        check("ab_hold_result", rif.result, 255);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("ab_idle_block", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
